mips_mdu: RTL and testbench
===========================

# mips_mdu

Iterative multiply/divide unit sitting directly downstream of `mips_registers`. It consumes the two register read ports (`read_data_1`, `read_data_2`) as operands, computes a 64-bit product or a quotient/remainder pair over multiple cycles, and holds the result in `hi`/`lo`. On completion it drives the register file write port (`signal_reg_write`, `write_reg`, `write_data`) for one cycle with `lo`.

## Interface
- `WIDTH`, 32: operand/result width.
- `REG_ADDR_WIDTH`, 3: register address width; matches the 8-entry register file.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 multu, 01 mult (signed), 10 divu, 11 div (signed).
- `operand_a`  in  WIDTH  multiplicand/dividend (from `read_data_1`).
- `operand_b`  in  WIDTH  multiplier/divisor (from `read_data_2`).
- `dest_reg`  in  REG_ADDR_WIDTH  writeback destination; captured with `start`.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse (state == WB).
- `hi`  out  WIDTH  product[63:32] or remainder.
- `lo`  out  WIDTH  product[31:0] or quotient.
- `div_by_zero`  out  1  valid with `done`; high for a divide with `operand_b` == 0.
- `signal_reg_write`  out  1  register file write enable; equals `done` except where stated below.
- `write_reg`  out  REG_ADDR_WIDTH  captured `dest_reg`.
- `write_data`  out  WIDTH  equals `lo`.

## Operation
- States: IDLE, CALC, FIX, WB.
- IDLE, `start`=1: capture `op`, `dest_reg`, operand magnitudes, and operand signs. Signs are used only for `op`[0]=1. Clear the 6-bit counter and go to CALC.
- Exception: a divide with `operand_b`=0 goes directly to WB. On that edge it loads hi=`operand_a` and lo=32'hFFFFFFFF, and sets `div_by_zero`.
- CALC: one iteration per cycle for exactly 32 cycles, then go to FIX.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring shift-subtract.
- FIX: apply sign correction and load `hi`/`lo`, then go to WB.
  - Signed mult: negate the 64-bit product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ. The remainder takes the dividend's sign.
  - Unsigned ops: no correction.
  - Signed -2^31 / -1 yields lo=32'h80000000, hi=0, with no flag.
- WB: `done`=1, `signal_reg_write`=1, `write_reg`=captured dest, `write_data`=`lo`. Go to IDLE on the next edge.
- `start` outside IDLE is ignored. There is no queueing.
- `hi`/`lo` hold their value until the next operation's FIX (or divide-by-zero) edge.
- `div_by_zero` is cleared when the next `start` is accepted.

## Timing
- Reset values: state IDLE, `busy`/`done`/`signal_reg_write`/`div_by_zero` = 0, `hi`/`lo`/`write_data` = 0, `write_reg` = 0.
- Edge numbering: `start` is sampled on edge E0. CALC occupies E1..E32, FIX loads on E33.
- `done` is high during the cycle after E33 and returns to IDLE at E34, so latency is 34 cycles from `start` to `done`.
- `busy` is high from after E0 until after E34.
- Divide by zero: `done` is high in the cycle right after E0.
- Back-to-back: a new `start` is accepted in the cycle after the `done` cycle.
- Reset during any state takes priority on the next edge: return to IDLE with reset values, and suppress any pending write.

## Configuration
- `MDU_DIV_EN` defined: divide datapath and ops 10/11 are implemented as described above.
- `MDU_DIV_EN` undefined: divide logic is omitted.
  - Ops 10/11 go E0 -> WB with `done` high in the next cycle.
  - `signal_reg_write`=0 and `div_by_zero`=0.
  - `hi`/`lo` remain unchanged.
  - Multiply behaviour is identical in both builds.

## Test plan
- multu, a=7, b=6, dest=3'b101 -> `done` 34 cycles after `start`; lo=42, hi=0; `signal_reg_write` one cycle with write_reg=101, write_data=42.
- mult, a=32'hFFFFFFFD, b=5 -> lo=32'hFFFFFFF1, hi=32'hFFFFFFFF.
- Two divides:
  - div, a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - divu, a=32'hF00F0FF5, b=32'h10 -> lo=32'h0F00F0FF, hi=5.
- divu, a=9, b=0 -> `done` one cycle after `start`; hi=9, lo=32'hFFFFFFFF, `div_by_zero`=1, write to dest occurs.
- Busy/reset handling: second `start` asserted during CALC is ignored (result of the first op only). `reset` asserted in CALC cycle 10 -> IDLE next edge, `busy`=0, hi=lo=0, no `signal_reg_write` pulse.
- Build without `MDU_DIV_EN`: divu 9/3 after multu 7*6 -> `done` next cycle, hi=0, lo=42 unchanged, `signal_reg_write`=0.

Source files
------------

// File: rtl/mips_mdu.sv
// mips_mdu -- iterative multiply/divide unit fed by the register file read ports.
//
// Computes a 64-bit product (shift-add) or a quotient/remainder pair (restoring
// shift-subtract) over 32 iteration cycles. Results are held in hi/lo, and lo is
// written back to the register file for one cycle on completion.
//
// Build option: define MDU_DIV_EN to include the divide datapath (ops 10/11).
// Without it, ops 10/11 complete immediately with no writeback. In that build
// div_by_zero stays low and hi/lo are left unchanged.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, op             request (sampled in IDLE); 00 multu, 01 mult, 10 divu, 11 div
//   operand_a, operand_b  multiplicand/dividend, multiplier/divisor
//   dest_reg              writeback destination, captured with start
//   busy, done            state != IDLE; one-cycle completion pulse
//   hi, lo                product[63:32]/remainder, product[31:0]/quotient
//   div_by_zero           valid with done; divide with zero divisor
//   signal_reg_write      register file write enable
//   write_reg, write_data captured dest_reg, lo
module mips_mdu #(
  parameter int WIDTH          = 32,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [WIDTH-1:0]          operand_a,
  input  logic [WIDTH-1:0]          operand_b,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          hi,
  output logic [WIDTH-1:0]          lo,
  output logic                      div_by_zero,
  output logic                      signal_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic [WIDTH-1:0]          write_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]                state;
  logic [5:0]                cnt;
  logic [1:0]                op_r;
  logic [REG_ADDR_WIDTH-1:0] dest_r;
  logic                      sign_a;
  logic                      sign_b;
  logic                      wr_en;
  logic                      dbz;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]          opnd;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0]        acc;

  logic [WIDTH-1:0]          a_mag;
  logic [WIDTH-1:0]          b_mag;
  logic [WIDTH:0]            mul_sum;
  logic [2*WIDTH-1:0]        mul_next;

  // Magnitudes are only taken for signed ops; unsigned operands pass through.
  assign a_mag = cond_neg(operand_a, op[0] & operand_a[WIDTH-1]);
  assign b_mag = cond_neg(operand_b, op[0] & operand_b[WIDTH-1]);

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic [WIDTH:0]            div_shift;
  logic [WIDTH:0]            div_diff;
  logic [2*WIDTH-1:0]        div_next;

  // Restoring step: keep the subtraction only when it does not go negative.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      dbz    <= 1'b0;
      wr_en  <= 1'b0;
      dest_r <= '0;
    end else begin
      case (state)
        // ---- IDLE: capture request ----
        IDLE: begin
          if (start) begin
            op_r   <= op;
            dest_r <= dest_reg;
            sign_a <= op[0] & operand_a[WIDTH-1];
            sign_b <= op[0] & operand_b[WIDTH-1];
            opnd   <= op[1] ? b_mag : a_mag;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt    <= '0;
            dbz    <= 1'b0;
            wr_en  <= 1'b1;
            if (op[1]) begin
`ifdef MDU_DIV_EN
              if (operand_b == '0) begin
                hi    <= operand_a;
                lo    <= '1;
                dbz   <= 1'b1;
                state <= WB;
              end else begin
                state <= CALC;
              end
`else
              wr_en <= 1'b0;
              state <= WB;
`endif
            end else begin
              state <= CALC;
            end
          end
        end
        // ---- CALC: one iteration per cycle ----
        CALC: begin
`ifdef MDU_DIV_EN
          acc <= op_r[1] ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        // ---- FIX: sign correction and result load ----
        FIX: begin
          if (!op_r[1]) begin
            {hi, lo} <= cond_neg2(acc, sign_a ^ sign_b);
          end
`ifdef MDU_DIV_EN
          else begin
            lo <= cond_neg(acc[WIDTH-1:0], sign_a ^ sign_b);
            hi <= cond_neg(acc[2*WIDTH-1:WIDTH], sign_a);
          end
`endif
          state <= WB;
        end
        // ---- WB: writeback pulse ----
        default: state <= IDLE;
      endcase
    end
  end

  assign busy             = (state != IDLE);
  assign done             = (state == WB);
  assign signal_reg_write = done & wr_en;
  assign div_by_zero      = dbz;
  assign write_reg        = dest_r;
  assign write_data       = lo;

endmodule

// File: tb/tb_mips_mdu.sv
module tb_mips_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [2:0]  dest_reg;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;
  logic        signal_reg_write;
  logic [2:0]  write_reg;
  logic [31:0] write_data;

  int n_assert = 0;
  int n_fail   = 0;

  mips_mdu #(.WIDTH(32), .REG_ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .signal_reg_write(signal_reg_write), .write_reg(write_reg), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] d);
    op = o; operand_a = a; operand_b = b; dest_reg = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts cycles after the start edge until done is seen (bounded).
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] d, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_srw, input logic exp_dbz);
    int cyc;
    issue(o, a, b, d);
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    wait_done(1, cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_srw"}, 64'(signal_reg_write), 64'(exp_srw));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    if (exp_srw) begin
      chk({tag, "_wreg"}, 64'(write_reg), 64'(d));
      chk({tag, "_wdata"}, 64'(write_data), 64'(exp_lo));
    end
    step();
    chk({tag, "_done_off"}, 64'({done, signal_reg_write, busy}), 64'(0));
  endtask

  initial begin
    int cyc;
    int srw_seen;
    reset = 1'b1; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    step();
    step();
    chk("rst_ctrl", 64'({busy, done, signal_reg_write, div_by_zero}), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'(0));
    chk("rst_wr", 64'({write_reg, write_data}), 64'(0));
    reset = 1'b0;
    step();
    chk("idle_busy", 64'(busy), 64'(0));

    run_op("multu_7x6", 2'b00, 32'd7, 32'd6, 3'b101, 34, 32'd0, 32'd42, 1'b1, 1'b0);
    // Back-to-back: issued in the cycle right after the done cycle.
    run_op("mult_neg3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 3'b010, 34,
           32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 1'b0);
    run_op("mult_neg3xneg5", 2'b01, 32'hFFFFFFFD, 32'hFFFFFFFB, 3'b001, 34,
           32'd0, 32'd15, 1'b1, 1'b0);
    run_op("mult_min_x2", 2'b01, 32'h80000000, 32'd2, 3'b011, 34,
           32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    run_op("multu_max_sq", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 34,
           32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);

    // Second start during CALC must be ignored; hi/lo hold until FIX.
    issue(2'b00, 32'd3, 32'd4, 3'b001);
    repeat (5) step();
    chk("hold_hi", 64'(hi), 64'hFFFFFFFE);
    chk("hold_lo", 64'(lo), 64'h1);
    op = 2'b00; operand_a = 32'd100; operand_b = 32'd100; dest_reg = 3'b010; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(7, cyc);
    chk("ign_latency", 64'(cyc), 64'(34));
    chk("ign_lo", 64'(lo), 64'(12));
    chk("ign_wreg", 64'(write_reg), 64'(1));
    step();
    step();
    chk("ign_no_second", 64'(busy), 64'(0));

    // Reset in CALC cycle 10 aborts the op with no writeback.
    issue(2'b00, 32'd7, 32'd6, 3'b011);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_calc_busy", 64'(busy), 64'(0));
    chk("rst_calc_hilo", {hi, lo}, 64'(0));
    srw_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (signal_reg_write || done) srw_seen++;
      step();
    end
    chk("rst_calc_no_wb", 64'(srw_seen), 64'(0));

`ifdef MDU_DIV_EN
    run_op("div_neg7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 3'b100, 34,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0);
    run_op("divu_big", 2'b10, 32'hF00F0FF5, 32'h10, 3'b001, 34,
           32'd5, 32'h0F00F0FF, 1'b1, 1'b0);
    run_op("div_7_neg2", 2'b11, 32'd7, 32'hFFFFFFFE, 3'b010, 34,
           32'd1, 32'hFFFFFFFD, 1'b1, 1'b0);
    run_op("div_min_neg1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 3'b011, 34,
           32'd0, 32'h80000000, 1'b1, 1'b0);
    run_op("divu_by0", 2'b10, 32'd9, 32'd0, 3'b110, 1,
           32'd9, 32'hFFFFFFFF, 1'b1, 1'b1);
    run_op("divu_8_3", 2'b10, 32'd8, 32'd3, 3'b111, 34,
           32'd2, 32'd2, 1'b1, 1'b0);
`else
    run_op("multu_pre", 2'b00, 32'd7, 32'd6, 3'b101, 34, 32'd0, 32'd42, 1'b1, 1'b0);
    run_op("nodiv_divu", 2'b10, 32'd9, 32'd3, 3'b001, 1, 32'd0, 32'd42, 1'b0, 1'b0);
    run_op("nodiv_div0", 2'b11, 32'd5, 32'd0, 3'b010, 1, 32'd0, 32'd42, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
